// File: rtl/fetch_buf_stage.sv
// fetch_buf_stage: instruction fetch over an in-order req/addr_ok/data_ok bus, pending-PC queue, output FIFO.
// Latency: data_ok in cycle T shows on out_* in T+1; a redirect empties the FIFO for the next cycle.
// Backpressure: out_ready stalls the FIFO; fetch credits drop inst_req before the FIFO could overflow.
// Optional feature macro FETCH_ADEF_EN: misaligned fetch PCs produce an out_adef entry instead of a bus request.
module fetch_buf_stage #(
  parameter int                ADDR_W          = 32,
  parameter int                DATA_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(32'h1c00_0000),
  parameter int                BUF_DEPTH       = 4,
  parameter int                MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_req,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_addr_ok,
  input  logic              inst_data_ok,
  input  logic [DATA_W-1:0] inst_rdata,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_inst,
`ifdef FETCH_ADEF_EN
  output logic              out_adef,
`endif
  input  logic              out_ready
);

  localparam int CW = $clog2(BUF_DEPTH + MAX_OUTSTANDING + 1);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [QW-1:0] QLAST   = QW'(MAX_OUTSTANDING - 1);

  logic              run;
  logic [ADDR_W-1:0] pc;
  logic [CW-1:0]     fifo_count, outstanding, cancel_cnt, outstanding_nxt;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] buf_pc   [BUF_DEPTH];
  logic [DATA_W-1:0] buf_inst [BUF_DEPTH];
  logic [ADDR_W-1:0] pend_pc  [MAX_OUTSTANDING];
  logic [QW-1:0]     pend_rd, pend_wr;
  logic              credit, accept, resp, keep, push, pop;
  logic [ADDR_W-1:0] push_pc;
  logic [DATA_W-1:0] push_inst;
`ifdef FETCH_ADEF_EN
  logic              misaligned, adef_push, adef_done, push_adef;
  logic              buf_adef [BUF_DEPTH];
`endif

  assign inst_addr = {pc[ADDR_W-1:2], 2'b00};
  assign out_valid = (fifo_count != '0);
  assign out_pc    = buf_pc[rd_ptr];
  assign out_inst  = buf_inst[rd_ptr];
`ifdef FETCH_ADEF_EN
  assign out_adef  = buf_adef[rd_ptr];
`endif

  // Credit check, bus handshakes and FIFO push/pop decisions for this cycle
  always_comb begin
    // Stale requests still hold outstanding slots, so the credit sum covers every response that can return
    credit = (outstanding < MAXO_C) && ((fifo_count + outstanding) < DEPTH_C);
`ifdef FETCH_ADEF_EN
    misaligned = (pc[1:0] != 2'b00);
    inst_req   = run && credit && !misaligned;
    // Only misaligned PCs reached via redirect exist; wait for stale responses to drain first
    adef_push  = run && misaligned && !adef_done && (outstanding == '0) &&
                 (fifo_count < DEPTH_C) && !redirect_valid;
`else
    inst_req   = run && credit;
`endif
    accept    = inst_req && inst_addr_ok;
    resp      = inst_data_ok && (outstanding != '0);
    keep      = resp && (cancel_cnt == '0) && !redirect_valid;
    pop       = out_valid && out_ready && !redirect_valid;
    push_pc   = pend_pc[pend_rd];
    push_inst = inst_rdata;
`ifdef FETCH_ADEF_EN
    push_adef = 1'b0;
    push      = keep || adef_push;
    if (adef_push) begin
      push_pc   = pc;
      push_inst = '0;
      push_adef = 1'b1;
    end
`else
    push      = keep;
`endif
    outstanding_nxt = outstanding + CW'(accept) - CW'(resp);
  end

  // Fetch PC, outstanding credit and stale-response accounting
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run         <= 1'b0;
      pc          <= RESET_PC;
      outstanding <= '0;
      cancel_cnt  <= '0;
`ifdef FETCH_ADEF_EN
      adef_done   <= 1'b0;
`endif
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything accepted up to and including this cycle and still unanswered is stale
        pc         <= redirect_pc;
        cancel_cnt <= outstanding_nxt;
`ifdef FETCH_ADEF_EN
        adef_done  <= 1'b0;
`endif
      end else begin
        if (accept) pc <= pc + ADDR_W'(4);
        if (resp && (cancel_cnt != '0)) cancel_cnt <= cancel_cnt - CW'(1);
`ifdef FETCH_ADEF_EN
        if (adef_push) adef_done <= 1'b1;
`endif
      end
    end
  end

  // In-order queue of PCs for requests accepted but not yet answered
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_rd <= '0;
      pend_wr <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) pend_pc[i] <= '0;
    end else begin
      if (accept) begin
        pend_pc[pend_wr] <= pc;
        pend_wr          <= (pend_wr == QLAST) ? '0 : pend_wr + QW'(1);
      end
      if (resp) pend_rd <= (pend_rd == QLAST) ? '0 : pend_rd + QW'(1);
    end
  end

  // Instruction FIFO towards decode; redirect empties it
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_pc[i]   <= '0;
        buf_inst[i] <= '0;
`ifdef FETCH_ADEF_EN
        buf_adef[i] <= 1'b0;
`endif
      end
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        buf_pc[wr_ptr]   <= push_pc;
        buf_inst[wr_ptr] <= push_inst;
`ifdef FETCH_ADEF_EN
        buf_adef[wr_ptr] <= push_adef;
`endif
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_buf_stage.sv
// Bench for fetch_buf_stage: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_fetch_buf_stage;
  localparam int          DEPTH = 4;
  localparam int          MAXO  = 2;
  localparam logic [31:0] RPC   = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok = 1'b0;
  logic        inst_data_ok = 1'b0;
  logic [31:0] inst_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
`ifdef FETCH_ADEF_EN
  logic        out_adef;
`endif

  int checks = 0;
  int failures = 0;

  fetch_buf_stage dut (
    .clk(clk), .resetn(resetn),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
`ifdef FETCH_ADEF_EN
    .out_adef(out_adef),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: requests in flight carry a stale flag, decode sees a plain queue
  typedef struct packed { logic [31:0] pc; logic stale; } pend_t;
  typedef struct packed { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;
  pend_t       pend[$];
  ent_t        mfifo[$];
  bit          m_run = 1'b0;
  logic [31:0] m_pc = RPC;
  bit          m_adef_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_req();
    bit r;
    r = m_run && (pend.size() < MAXO) && ((mfifo.size() + pend.size()) < DEPTH);
`ifdef FETCH_ADEF_EN
    if (m_pc[1:0] != 2'b00) r = 1'b0;
`endif
    return r;
  endfunction

  function automatic void model_reset();
    pend.delete();
    mfifo.delete();
    m_run = 1'b0;
    m_pc = RPC;
    m_adef_done = 1'b0;
  endfunction

  function automatic void model_step(input bit rv, input logic [31:0] rpc, input bit aok,
                                     input bit dok, input logic [31:0] rd, input bit ordy);
    bit    acc, adef_now;
    pend_t p;
    ent_t  e;
    acc = exp_req() && aok;
    adef_now = 1'b0;
`ifdef FETCH_ADEF_EN
    adef_now = m_run && (m_pc[1:0] != 2'b00) && !m_adef_done && (pend.size() == 0) &&
               (mfifo.size() < DEPTH) && !rv;
`endif
    if (mfifo.size() > 0 && ordy && !rv) void'(mfifo.pop_front());
    if (dok && pend.size() > 0) begin
      p = pend.pop_front();
      if (!p.stale && !rv) begin
        e.pc = p.pc; e.inst = rd; e.adef = 1'b0;
        mfifo.push_back(e);
      end
    end
    if (adef_now) begin
      e.pc = m_pc; e.inst = '0; e.adef = 1'b1;
      mfifo.push_back(e);
      m_adef_done = 1'b1;
    end
    if (acc) begin
      p.pc = m_pc; p.stale = rv;
      pend.push_back(p);
    end
    if (rv) begin
      for (int i = 0; i < pend.size(); i++) begin
        p = pend[i]; p.stale = 1'b1; pend[i] = p;
      end
      mfifo.delete();
      m_pc = rpc;
      m_adef_done = 1'b0;
    end else if (acc) begin
      m_pc = m_pc + 32'd4;
    end
    m_run = 1'b1;
  endfunction

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    chk("inst_req", inst_req, exp_req());
    if (exp_req()) chk("inst_addr", inst_addr, {m_pc[31:2], 2'b00});
    chk("out_valid", out_valid, mfifo.size() != 0);
    if (mfifo.size() != 0) begin
      chk("out_pc", out_pc, mfifo[0].pc);
      chk("out_inst", out_inst, mfifo[0].inst);
`ifdef FETCH_ADEF_EN
      chk("out_adef", out_adef, mfifo[0].adef);
`endif
    end
  end

  // Applies one cycle of inputs, advances the model, returns just after the next falling edge
  task automatic tick(input bit rv, input logic [31:0] rpc, input bit aok, input bit dok, input bit ordy);
    logic [31:0] rd;
    rd = $urandom;
    redirect_valid = rv; redirect_pc = rpc; inst_addr_ok = aok;
    inst_data_ok = dok; inst_rdata = rd; out_ready = ordy;
    if (resetn) model_step(rv, rpc, aok, dok, rd, ordy);
    @(negedge clk); #1;
  endtask

  task automatic stream_from_reset(input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (out_valid) found = 1'b1;
      else tick(1'b0, '0, 1'b1, pend.size() > 0, 1'b1);
    end
    chk({tag, "_first_valid"}, found, 1'b1);
    chk({tag, "_pc0"}, out_pc, 32'h1c00_0000);
    tick(1'b0, '0, 1'b1, pend.size() > 0, 1'b1);
    chk({tag, "_pc1"}, out_pc, 32'h1c00_0004);
    tick(1'b0, '0, 1'b1, pend.size() > 0, 1'b1);
    chk({tag, "_pc2"}, out_pc, 32'h1c00_0008);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int          cnt;
    logic [31:0] prev, rpc;
    bit          rv;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req", inst_req, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
`ifdef FETCH_ADEF_EN
    chk("rst_adef", out_adef, 1'b0);
`endif
    resetn = 1'b1;

    // Streaming with single-cycle response latency
    stream_from_reset("t1");
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, '0, 1'b1, pend.size() > 0, 1'b1);
      chk("t1_sustain", out_valid, 1'b1);
    end

    // Decode stalled: FIFO fills to BUF_DEPTH, then drains in order
    for (int i = 0; i < 12; i++) tick(1'b0, '0, 1'b1, pend.size() > 0, 1'b0);
    chk("t2_req_off", inst_req, 1'b0);
    chk("t2_full_valid", out_valid, 1'b1);
    cnt = 0; prev = '0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) begin
        if (cnt > 0) chk("t2_order", out_pc, prev + 32'd4);
        prev = out_pc;
        cnt++;
      end
      tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    end
    chk("t2_count", cnt, 4);

    // Two in flight, redirect: both responses discarded
    tick(1'b1, 32'h1c00_0000, 1'b0, 1'b0, 1'b1);
    chk("t3_req", inst_req, 1'b1);
    chk("t3_addr0", inst_addr, 32'h1c00_0000);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t3_addr1", inst_addr, 32'h1c00_0004);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t3_req_max", inst_req, 1'b0);
    tick(1'b1, 32'h1c00_0100, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t3_dropped", out_valid, 1'b0);
    chk("t3_addr_tgt", inst_addr, 32'h1c00_0100);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t3_valid", out_valid, 1'b1);
    chk("t3_pc", out_pc, 32'h1c00_0100);

    // Redirect coinciding with accept and data_ok
    tick(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t4_req", inst_req, 1'b1);
    tick(1'b1, 32'h1c00_0200, 1'b1, 1'b1, 1'b1);
    chk("t4_flushed", out_valid, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_stale_drop", out_valid, 1'b0);
    chk("t4_addr_tgt", inst_addr, 32'h1c00_0200);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    chk("t4_valid", out_valid, 1'b1);
    chk("t4_pc", out_pc, 32'h1c00_0200);

`ifdef FETCH_ADEF_EN
    // Misaligned redirect target: no bus request, one adef entry
    for (int i = 0; i < 10 && pend.size() > 0; i++) tick(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b1, 32'h1c00_0102, 1'b0, 1'b0, 1'b0);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_req", inst_req, 1'b0);
    chk("t6_valid", out_valid, 1'b1);
    chk("t6_adef", out_adef, 1'b1);
    chk("t6_pc", out_pc, 32'h1c00_0102);
    chk("t6_inst", out_inst, 32'h0);
    tick(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t6_stall", inst_req, 1'b0);
    tick(1'b1, 32'h1c00_0300, 1'b0, 1'b0, 1'b1);
`endif

    // Random traffic with redirects, PC wrap and spurious data_ok
    for (int i = 0; i < 3000; i++) begin
      rv = ($urandom % 30) == 0;
      rpc = 32'h1c00_0000 + ($urandom % 1024) * 4;
      if ($urandom % 6 == 0) rpc = rpc + ($urandom % 4);
      if ($urandom % 10 == 0) rpc = 32'hffff_fff8;
      tick(rv, rpc, ($urandom % 4) != 0,
           (pend.size() > 0) ? (($urandom % 3) != 0) : (($urandom % 16) == 0),
           ($urandom % 4) != 0);
    end

    // Reset asserted with two requests in flight
    tick(1'b1, 32'h1c00_0400, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 12 && pend.size() < 2; i++) tick(1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk("t5_req_max", inst_req, 1'b0);
    resetn = 1'b0;
    model_reset();
    #1;
    chk("t5_rst_valid", out_valid, 1'b0);
    chk("t5_rst_req", inst_req, 1'b0);
    chk("t5_rst_pc", out_pc, 32'h0);
    repeat (3) tick(1'b0, '0, 1'b1, 1'b1, 1'b1);
    resetn = 1'b1;
    stream_from_reset("t5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
